// File: rtl/lockin_result_avg.sv
// lockin_result_avg
// -----------------------------------------------------------------------------
// Decimating boxcar averager for the carrier-sync phase word, with a lock
// indicator derived from the loop-filter frequency error.
//
// Every 2^LOG2N accepted samples of phase_in produce one signed mean on
// avg_out, offered to the consumer through a valid/ready handshake. A mean
// that completes while the previous one is still unconsumed is dropped, and
// the sticky overrun flag records the loss. Over the same window the largest
// |df_in| is tracked. A window counts as "in lock" when that maximum stays at
// or below LOCK_THR. LOCK_CNT consecutive in-lock windows assert locked.
//
// Ports:
//   clk        processing clock (10 MHz domain)
//   rst        synchronous reset, active low
//   clear      synchronous flush of the window being accumulated
//   in_valid   strobe qualifying phase_in / df_in
//   phase_in   signed phase-detector filter output (DW bits)
//   df_in      signed loop-filter frequency error (FW bits)
//   out_ready  consumer accepts avg_out this cycle
//   out_valid  avg_out holds an unconsumed mean
//   avg_out    signed window mean (DW bits)
//   locked     carrier lock indicator
//   overrun    sticky: a completed mean was dropped
//   win_cnt    samples accepted so far in the current window
// -----------------------------------------------------------------------------
module lockin_result_avg #(
  parameter int              DW       = 34,
  parameter int              FW       = 25,
  parameter int              LOG2N    = 10,
  parameter logic [FW-1:0]   LOCK_THR = 25'd4096,
  parameter int              LOCK_CNT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [DW-1:0]    phase_in,
  input  logic [FW-1:0]    df_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [DW-1:0]    avg_out,
  output logic             locked,
  output logic             overrun,
  output logic [LOG2N-1:0] win_cnt
);

  localparam int              AW       = DW + LOG2N;
  localparam logic [LOG2N-1:0] LAST_IDX = '1;
  localparam logic [7:0]      LOCK_SAT = 8'(LOCK_CNT);
  localparam logic [FW-1:0]   DF_MIN   = {1'b1, {(FW-1){1'b0}}};
  localparam logic [FW-1:0]   DF_MAX   = {1'b0, {(FW-1){1'b1}}};

  logic [AW-1:0] acc;
  logic [AW-1:0] acc_sum;
  logic [AW-1:0] phase_ext;
  logic [DW-1:0] mean;
  logic [FW-1:0] max_df;
  logic [FW-1:0] abs_df;
  logic [FW-1:0] win_max_df;
  logic [7:0]    lock_cnt;
  logic [7:0]    lock_cnt_next;
  logic          win_end;
  logic          win_ok;

  // Datapath for the current sample.
  // The mean is acc_sum >>> LOG2N truncated to DW bits, which is exactly the
  // bit slice [AW-1:LOG2N]. Slicing floors toward -inf like an arithmetic
  // shift. The magnitude of the most negative df is saturated so that it
  // still compares as "large" instead of wrapping back to itself.
  always_comb begin
    phase_ext     = {{LOG2N{phase_in[DW-1]}}, phase_in};
    acc_sum       = acc + phase_ext;
    mean          = acc_sum[AW-1:LOG2N];
    abs_df        = df_in;
    if (df_in == DF_MIN) begin
      abs_df = DF_MAX;
    end else if (df_in[FW-1]) begin
      abs_df = -df_in;
    end
    win_max_df    = (abs_df > max_df) ? abs_df : max_df;
    win_end       = in_valid && !clear && (win_cnt == LAST_IDX);
    win_ok        = (win_max_df <= LOCK_THR);
    lock_cnt_next = (lock_cnt == LOCK_SAT) ? lock_cnt : lock_cnt + 8'd1;
  end

  // Window accumulation state.
  // clear wins over a window end, so a flushed sample never reaches the
  // output. At window end everything restarts so that the next accepted
  // sample is the first of a fresh window.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc     <= '0;
      win_cnt <= '0;
      max_df  <= '0;
    end else if (clear || win_end) begin
      acc     <= '0;
      win_cnt <= '0;
      max_df  <= '0;
    end else if (in_valid) begin
      acc     <= acc_sum;
      win_cnt <= win_cnt + 1'b1;
      max_df  <= win_max_df;
    end
  end

  // Output holding register with valid/ready handshake.
  // A new mean may replace the held one only if the slot is empty or being
  // consumed in the same cycle. Otherwise it is lost and overrun latches.
  always_ff @(posedge clk) begin
    if (!rst) begin
      avg_out   <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (win_end) begin
      if (!out_valid || out_ready) begin
        avg_out   <= mean;
        out_valid <= 1'b1;
      end else begin
        overrun   <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Lock detector, judged once per completed window.
  // The window maximum includes the df of the closing sample itself.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (win_end) begin
      if (win_ok) begin
        lock_cnt <= lock_cnt_next;
        locked   <= (lock_cnt_next == LOCK_SAT);
      end else begin
        lock_cnt <= '0;
        locked   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lockin_result_avg.sv
// tb_lockin_result_avg
// -----------------------------------------------------------------------------
// Directed testbench for lockin_result_avg with a 4-sample window
// (LOG2N=2), LOCK_THR=100 and LOCK_CNT=2. Each scenario task drives its
// samples and compares the registered outputs 1 ns after the clock edge
// against hand-computed values.
// -----------------------------------------------------------------------------
module tb_lockin_result_avg;

  localparam int DW = 34;
  localparam int FW = 25;
  localparam int LOG2N = 2;

  logic             clk;
  logic             rst;
  logic             clear;
  logic             in_valid;
  logic [DW-1:0]    phase_in;
  logic [FW-1:0]    df_in;
  logic             out_ready;
  logic             out_valid;
  logic [DW-1:0]    avg_out;
  logic             locked;
  logic             overrun;
  logic [LOG2N-1:0] win_cnt;

  int tests_run;
  int tests_failed;

  lockin_result_avg #(
    .DW(DW), .FW(FW), .LOG2N(LOG2N), .LOCK_THR(25'd100), .LOCK_CNT(2)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .phase_in(phase_in), .df_in(df_in), .out_ready(out_ready),
    .out_valid(out_valid), .avg_out(avg_out), .locked(locked),
    .overrun(overrun), .win_cnt(win_cnt)
  );

  // 10 MHz processing clock.
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Present one cycle of input and advance to just after the next edge.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] p, input logic [FW-1:0] d);
    in_valid = v;
    phase_in = p;
    df_in    = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) applyStimulus(1'b0, '0, '0);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %0d, expected 0", out_valid); end
    tests_run++; if (avg_out !== '0) begin tests_failed++; $display("[TB] FAIL reset_avg_out: got %0d, expected 0", $signed(avg_out)); end
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_locked: got %0d, expected 0", locked); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_overrun: got %0d, expected 0", overrun); end
    tests_run++; if (win_cnt !== '0) begin tests_failed++; $display("[TB] FAIL reset_win_cnt: got %0d, expected 0", win_cnt); end
    rst = 1'b1;
  endtask

  task automatic test_basic_mean();
    out_ready = 1'b1;
    applyStimulus(1'b1, 34'd10, '0);
    applyStimulus(1'b1, 34'd20, '0);
    tests_run++; if (win_cnt !== 2'd2) begin tests_failed++; $display("[TB] FAIL basic_win_cnt_mid: got %0d, expected 2", win_cnt); end
    applyStimulus(1'b1, 34'd30, '0);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_early_valid: got %0d, expected 0", out_valid); end
    applyStimulus(1'b1, 34'd40, '0);
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_out_valid: got %0d, expected 1", out_valid); end
    tests_run++; if (avg_out !== 34'd25) begin tests_failed++; $display("[TB] FAIL basic_avg: got %0d, expected 25", $signed(avg_out)); end
    tests_run++; if (win_cnt !== 2'd0) begin tests_failed++; $display("[TB] FAIL basic_win_cnt_wrap: got %0d, expected 0", win_cnt); end
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_locked_first_window: got %0d, expected 0", locked); end
    applyStimulus(1'b0, '0, '0);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_valid_one_cycle: got %0d, expected 0", out_valid); end
  endtask

  task automatic test_rounding_fullscale();
    applyStimulus(1'b1, 34'(-1), '0);
    applyStimulus(1'b1, 34'(-2), '0);
    applyStimulus(1'b1, 34'(-2), '0);
    applyStimulus(1'b1, 34'(-2), '0);
    tests_run++; if (avg_out !== 34'(-2)) begin tests_failed++; $display("[TB] FAIL neg_round_avg: got %0d, expected -2", $signed(avg_out)); end
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("[TB] FAIL lock_second_window: got %0d, expected 1", locked); end
    applyStimulus(1'b0, '0, '0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 34'h1_FFFF_FFFF, '0);
    tests_run++; if (avg_out !== 34'h1_FFFF_FFFF) begin tests_failed++; $display("[TB] FAIL fullscale_avg: got %0d, expected 8589934591", $signed(avg_out)); end
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL fullscale_valid: got %0d, expected 1", out_valid); end
    applyStimulus(1'b0, '0, '0);
  endtask

  task automatic test_lock();
    // Window with one df just over threshold drops lock.
    applyStimulus(1'b1, '0, 25'd50);
    applyStimulus(1'b1, '0, 25'(-101));
    applyStimulus(1'b1, '0, 25'd0);
    applyStimulus(1'b1, '0, 25'd100);
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL lock_drop_minus101: got %0d, expected 0", locked); end
    // One good window, then a window containing the most negative df.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, '0, 25'(-100));
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL lock_one_good: got %0d, expected 0", locked); end
    applyStimulus(1'b1, '0, 25'd0);
    applyStimulus(1'b1, '0, 25'd0);
    applyStimulus(1'b1, '0, 25'd0);
    applyStimulus(1'b1, '0, 25'h100_0000);
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL lock_df_min: got %0d, expected 0", locked); end
    // The most negative df must have reset the count: one more good window is not enough.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, '0, 25'd7);
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL lock_count_restarted: got %0d, expected 0", locked); end
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, '0, 25'd7);
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("[TB] FAIL lock_regained: got %0d, expected 1", locked); end
    applyStimulus(1'b0, '0, '0);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    applyStimulus(1'b1, 34'd10, '0);
    applyStimulus(1'b1, 34'd20, '0);
    applyStimulus(1'b1, 34'd30, '0);
    applyStimulus(1'b1, 34'd40, '0);
    tests_run++; if (avg_out !== 34'd25 || out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_first_mean: got avg %0d valid %0d, expected 25 and 1", $signed(avg_out), out_valid); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_no_overrun_yet: got %0d, expected 0", overrun); end
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 34'd5, '0);
    tests_run++; if (avg_out !== 34'd25) begin tests_failed++; $display("[TB] FAIL bp_avg_kept: got %0d, expected 25", $signed(avg_out)); end
    tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_overrun_set: got %0d, expected 1", overrun); end
    out_ready = 1'b1;
    applyStimulus(1'b0, '0, '0);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_transfer: got %0d, expected 0", out_valid); end
    tests_run++; if (overrun !== 1'b1 || avg_out !== 34'd25) begin tests_failed++; $display("[TB] FAIL bp_sticky: got overrun %0d avg %0d, expected 1 and 25", overrun, $signed(avg_out)); end
  endtask

  task automatic test_gaps();
    // Idle cycles carry junk phase and a large df that must be ignored.
    applyStimulus(1'b1, 34'd8, '0);
    applyStimulus(1'b0, 34'd1000, 25'd5000);
    applyStimulus(1'b1, 34'd12, '0);
    applyStimulus(1'b0, 34'd1000, 25'd5000);
    tests_run++; if (win_cnt !== 2'd2) begin tests_failed++; $display("[TB] FAIL gaps_win_cnt: got %0d, expected 2", win_cnt); end
    applyStimulus(1'b1, 34'd16, '0);
    applyStimulus(1'b0, 34'd1000, 25'd5000);
    applyStimulus(1'b1, 34'd4, '0);
    tests_run++; if (avg_out !== 34'd10 || out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL gaps_avg: got avg %0d valid %0d, expected 10 and 1", $signed(avg_out), out_valid); end
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("[TB] FAIL gaps_locked: got %0d, expected 1", locked); end
    applyStimulus(1'b0, '0, '0);
  endtask

  task automatic test_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 34'd20, '0);
    applyStimulus(1'b1, 34'd100, '0);
    applyStimulus(1'b1, 34'd100, '0);
    clear = 1'b1;
    applyStimulus(1'b1, 34'd999, 25'd5000);
    clear = 1'b0;
    tests_run++; if (win_cnt !== 2'd0) begin tests_failed++; $display("[TB] FAIL clear_win_cnt: got %0d, expected 0", win_cnt); end
    tests_run++; if (out_valid !== 1'b1 || avg_out !== 34'd20) begin tests_failed++; $display("[TB] FAIL clear_output_kept: got valid %0d avg %0d, expected 1 and 20", out_valid, $signed(avg_out)); end
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("[TB] FAIL clear_locked_kept: got %0d, expected 1", locked); end
    out_ready = 1'b1;
    applyStimulus(1'b1, 34'd1, '0);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL clear_transfer: got %0d, expected 0", out_valid); end
    applyStimulus(1'b1, 34'd2, '0);
    applyStimulus(1'b1, 34'd3, '0);
    applyStimulus(1'b1, 34'd6, '0);
    tests_run++; if (avg_out !== 34'd3 || out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL clear_avg: got avg %0d valid %0d, expected 3 and 1", $signed(avg_out), out_valid); end
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("[TB] FAIL clear_window_locked: got %0d, expected 1", locked); end
    applyStimulus(1'b0, '0, '0);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 34'd40, '0);
    applyStimulus(1'b1, 34'd7, '0);
    applyStimulus(1'b1, 34'd7, '0);
    tests_run++; if (out_valid !== 1'b1 || locked !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_precondition: got valid %0d locked %0d, expected 1 and 1", out_valid, locked); end
    rst = 1'b0;
    applyStimulus(1'b1, 34'd7, '0);
    rst = 1'b1;
    tests_run++; if (out_valid !== 1'b0 || avg_out !== '0) begin tests_failed++; $display("[TB] FAIL mid_reset_output: got valid %0d avg %0d, expected 0 and 0", out_valid, $signed(avg_out)); end
    tests_run++; if (locked !== 1'b0 || overrun !== 1'b0 || win_cnt !== '0) begin tests_failed++; $display("[TB] FAIL mid_reset_flags: got locked %0d overrun %0d win_cnt %0d, expected 0 0 0", locked, overrun, win_cnt); end
    out_ready = 1'b1;
    applyStimulus(1'b1, 34'd10, '0);
    applyStimulus(1'b1, 34'd20, '0);
    applyStimulus(1'b1, 34'd30, '0);
    applyStimulus(1'b1, 34'd40, '0);
    tests_run++; if (avg_out !== 34'd25 || out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_fresh_avg: got avg %0d valid %0d, expected 25 and 1", $signed(avg_out), out_valid); end
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_fresh_locked: got %0d, expected 0", locked); end
    applyStimulus(1'b0, '0, '0);
  endtask

  // Scenario sequence.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    clear        = 1'b0;
    in_valid     = 1'b0;
    phase_in     = '0;
    df_in        = '0;
    out_ready    = 1'b1;
    test_reset();
    test_basic_mean();
    test_rounding_fullscale();
    test_lock();
    test_backpressure();
    test_gaps();
    test_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
